// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM type, direction constants and call-search helpers
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int MAX_FLOORS = 64;
    function automatic logic any_above(input int floor, input logic [MAX_FLOORS-1:0] vec);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) r = r | (i > floor && vec[i]);
        return r;
    endfunction
    function automatic logic any_below(input int floor, input logic [MAX_FLOORS-1:0] vec);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) r = r | (i < floor && vec[i]);
        return r;
    endfunction
endpackage

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: car/hall-up/hall-down pending registers, clear wins over set
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] car_set,
    input  logic [N_FLOORS-1:0] up_set,
    input  logic [N_FLOORS-1:0] down_set,
    input  logic [N_FLOORS-1:0] car_clr,
    input  logic [N_FLOORS-1:0] up_clr,
    input  logic [N_FLOORS-1:0] down_clr,
    output logic [N_FLOORS-1:0] car_pend,
    output logic [N_FLOORS-1:0] up_pend,
    output logic [N_FLOORS-1:0] down_pend
);
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DOWN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};
    always_ff @(posedge clk)
        if (rst) begin
            car_pend <= '0;
            up_pend <= '0;
            down_pend <= '0;
        end else begin
            car_pend <= (car_pend | car_set) & ~car_clr;
            up_pend <= (up_pend | up_set) & ~up_clr & UP_MASK;
            down_pend <= (down_pend | down_set) & ~down_clr & DOWN_MASK;
        end
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN collective-control car controller with registered motor/door outputs
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_BITS = $clog2(N_FLOORS),
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_FLOORS-1:0]   car_call,
    input  logic [N_FLOORS-1:0]   hall_up,
    input  logic [N_FLOORS-1:0]   hall_down,
    input  logic                  door_hold,
    output logic [FLOOR_BITS-1:0] current_floor,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  direction,
    output logic [N_FLOORS-1:0]   car_pend,
    output logic [N_FLOORS-1:0]   up_pend,
    output logic [N_FLOORS-1:0]   down_pend,
    output logic                  busy
);
    localparam int FW = FLOOR_BITS + 1;
    localparam int TW = TRAVEL_CYCLES > 1 ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = DOOR_CYCLES > 1 ? $clog2(DOOR_CYCLES) : 1;
    state_t state, state_n;
    logic [FLOOR_BITS-1:0] floor_n, nf;
    logic [FW-1:0] nf_w;
    logic [TW-1:0] travel_cnt, travel_cnt_n;
    logic [DW-1:0] door_cnt, door_cnt_n;
    logic dir_n, step_ok, cur_up, cur_dn, nxt_up, nxt_dn, ahead_cur, behind_cur, ahead_nf;
    logic here, opp_here, reopen, flip, stop;
    logic motor_up_n, motor_down_n, door_open_n, busy_n;
    logic [N_FLOORS-1:0] car_clr, up_clr, down_clr;
    logic [MAX_FLOORS-1:0] all_pend;
    elevator_call_latch #(.N_FLOORS(N_FLOORS)) u_latch (
        .clk(clk), .rst(rst),
        .car_set(car_call), .up_set(hall_up), .down_set(hall_down),
        .car_clr(car_clr), .up_clr(up_clr), .down_clr(down_clr),
        .car_pend(car_pend), .up_pend(up_pend), .down_pend(down_pend)
    );
    assign all_pend = MAX_FLOORS'(car_pend | up_pend | down_pend);
    assign nf_w = direction ? {1'b0, current_floor} + FW'(1) : {1'b0, current_floor} - FW'(1);
    assign step_ok = nf_w < FW'(N_FLOORS);
    assign nf = nf_w[FLOOR_BITS-1:0];
    assign cur_up = any_above(int'(current_floor), all_pend);
    assign cur_dn = any_below(int'(current_floor), all_pend);
    assign nxt_up = any_above(int'(nf), all_pend);
    assign nxt_dn = any_below(int'(nf), all_pend);
    assign ahead_cur = direction ? cur_up : cur_dn;
    assign behind_cur = direction ? cur_dn : cur_up;
    assign ahead_nf = direction ? nxt_up : nxt_dn;
    assign here = car_pend[current_floor] | up_pend[current_floor] | down_pend[current_floor];
    assign opp_here = direction ? down_pend[current_floor] : up_pend[current_floor];
    assign reopen = car_pend[current_floor] | car_call[current_floor] | (direction
        ? up_pend[current_floor] | (hall_up[current_floor] & (int'(current_floor) != N_FLOORS-1))
        : down_pend[current_floor] | (hall_down[current_floor] & (current_floor != '0)));
    assign flip = !ahead_nf && (direction ? down_pend[nf] : up_pend[nf]);
    assign stop = car_pend[nf] | (direction ? up_pend[nf] : down_pend[nf]) | flip;
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            current_floor <= '0;
            direction <= DIR_UP;
            travel_cnt <= '0;
            door_cnt <= '0;
            motor_up <= 1'b0;
            motor_down <= 1'b0;
            door_open <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            current_floor <= floor_n;
            direction <= dir_n;
            travel_cnt <= travel_cnt_n;
            door_cnt <= door_cnt_n;
            motor_up <= motor_up_n;
            motor_down <= motor_down_n;
            door_open <= door_open_n;
            busy <= busy_n;
        end
    always_comb begin
        state_n = state;
        floor_n = current_floor;
        dir_n = direction;
        travel_cnt_n = '0;
        door_cnt_n = '0;
        car_clr = '0;
        up_clr = '0;
        down_clr = '0;
        case (state)
            IDLE:
                if (here) begin
                    state_n = DOOR;
                    dir_n = up_pend[current_floor] ? DIR_UP : down_pend[current_floor] ? DIR_DOWN : direction;
                    car_clr[current_floor] = 1'b1;
                    up_clr[current_floor] = dir_n;
                    down_clr[current_floor] = !dir_n;
                end else if (ahead_cur) begin
                    state_n = MOVE;
                end else if (behind_cur) begin
                    state_n = MOVE;
                    dir_n = !direction;
                end
            MOVE:
                if (travel_cnt != TW'(TRAVEL_CYCLES-1)) begin
                    travel_cnt_n = travel_cnt + TW'(1);
                end else if (!step_ok) begin
                    state_n = IDLE;
                end else begin
                    floor_n = nf;
                    if (stop) begin
                        state_n = DOOR;
                        car_clr[nf] = 1'b1;
                        up_clr[nf] = direction | flip;
                        down_clr[nf] = !direction | flip;
                        dir_n = direction ^ flip;
                    end else if (!ahead_nf) begin
                        state_n = IDLE;
                    end
                end
            DOOR:
                // a same-direction or car call at this floor is absorbed and restarts the dwell
                if (door_hold || reopen) begin
                    car_clr[current_floor] = reopen;
                    up_clr[current_floor] = reopen & direction;
                    down_clr[current_floor] = reopen & !direction;
                end else if (door_cnt != DW'(DOOR_CYCLES-1)) begin
                    door_cnt_n = door_cnt + DW'(1);
                end else if (ahead_cur) begin
                    state_n = MOVE;
                end else if (opp_here) begin
                    dir_n = !direction;
                    up_clr[current_floor] = !direction;
                    down_clr[current_floor] = direction;
                end else if (behind_cur) begin
                    state_n = MOVE;
                    dir_n = !direction;
                end else begin
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        motor_up_n = state_n == MOVE && dir_n;
        motor_down_n = state_n == MOVE && !dir_n;
        door_open_n = state_n == DOOR;
        busy_n = state_n != IDLE;
    end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: vector table plus multi-cycle sequences for the SCAN controller
module tb_elevator_scan_ctrl;
    localparam int N = 4;
    typedef struct packed {
        logic [1:0]   floor;
        logic         mu;
        logic         md;
        logic         door;
        logic         dir;
        logic         busy;
        logic [N-1:0] car;
        logic [N-1:0] up;
        logic [N-1:0] dn;
    } obs_t;
    typedef struct {
        logic [N-1:0] car;
        logic [N-1:0] up;
        logic [N-1:0] dn;
        int           k;
        obs_t         exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] car_call = '0;
    logic [N-1:0] hall_up = '0;
    logic [N-1:0] hall_down = '0;
    logic door_hold = 1'b0;
    logic [1:0] current_floor;
    logic motor_up, motor_down, door_open, direction, busy;
    logic [N-1:0] car_pend, up_pend, down_pend;
    int n_cmp = 0;
    int n_fail = 0;
    vec_t tbl[$];
    obs_t sb[$];
    elevator_scan_ctrl #(.N_FLOORS(N), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .car_call(car_call), .hall_up(hall_up), .hall_down(hall_down),
        .door_hold(door_hold), .current_floor(current_floor), .motor_up(motor_up),
        .motor_down(motor_down), .door_open(door_open), .direction(direction),
        .car_pend(car_pend), .up_pend(up_pend), .down_pend(down_pend), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic obs_t mk(input int fl, input logic mu, md, dr, di, bz, input logic [N-1:0] c, u, d);
        obs_t o;
        o.floor = 2'(fl);
        o.mu = mu;
        o.md = md;
        o.door = dr;
        o.dir = di;
        o.busy = bz;
        o.car = c;
        o.up = u;
        o.dn = d;
        return o;
    endfunction
    function automatic obs_t cur();
        return obs_t'({current_floor, motor_up, motor_down, door_open, direction, busy, car_pend, up_pend, down_pend});
    endfunction
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        car_call = '0;
        hall_up = '0;
        hall_down = '0;
        door_hold = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask
    task automatic pulse(input logic [N-1:0] c, u, d);
        car_call = c;
        hall_up = u;
        hall_down = d;
        tick(1);
        car_call = '0;
        hall_up = '0;
        hall_down = '0;
    endtask
    task automatic chk(input string name, input obs_t exp);
        obs_t got;
        got = cur();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (floor mu md door dir busy car up dn)", name, got, exp);
        end
    endtask
    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic wait_door(output int n);
        n = 0;
        while (!door_open && n < 100) begin
            tick(1);
            n++;
        end
    endtask
    task automatic door_len(output int n, output int hits);
        n = 0;
        hits = 0;
        while (door_open && n < 200) begin
            if (car_pend[current_floor]) hits++;
            tick(1);
            n++;
        end
    endtask
    task automatic wait_floor(input int f, output int n);
        n = 0;
        while (int'(current_floor) != f && n < 200) begin
            tick(1);
            n++;
        end
    endtask
    task automatic add(input logic [N-1:0] c, u, d, input int k, input obs_t e);
        tbl.push_back('{c, u, d, k, e});
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        obs_t r, e;
        int n, hits;
        r = mk(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0);
        add(4'h1, 4'h0, 4'h0, 1,  mk(0, 0, 0, 0, 1, 0, 4'h1, 4'h0, 4'h0));
        add(4'h1, 4'h0, 4'h0, 2,  mk(0, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        add(4'h1, 4'h0, 4'h0, 9,  mk(0, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        add(4'h1, 4'h0, 4'h0, 10, r);
        add(4'h0, 4'h8, 4'h1, 2,  r);
        add(4'h0, 4'h1, 4'h0, 2,  mk(0, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        add(4'h0, 4'h0, 4'h4, 1,  mk(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h4));
        add(4'h0, 4'h0, 4'h4, 2,  mk(0, 1, 0, 0, 1, 1, 4'h0, 4'h0, 4'h4));
        add(4'h8, 4'h0, 4'h0, 6,  mk(1, 1, 0, 0, 1, 1, 4'h8, 4'h0, 4'h0));
        add(4'h8, 4'h0, 4'h0, 10, mk(2, 1, 0, 0, 1, 1, 4'h8, 4'h0, 4'h0));
        add(4'h8, 4'h0, 4'h0, 14, mk(3, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        add(4'h0, 4'h0, 4'h4, 10, mk(2, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0));
        add(4'h0, 4'h2, 4'h0, 6,  mk(1, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        add(4'h9, 4'h0, 4'h0, 2,  mk(0, 0, 0, 1, 1, 1, 4'h8, 4'h0, 4'h0));
        do_reset();
        tick(10);
        chk("t1_idle", r);
        pulse(4'h8, 4'h0, 4'h0);
        tick(5);
        chk("t1_moving", mk(1, 1, 0, 0, 1, 1, 4'h8, 4'h0, 4'h0));
        rst = 1'b1;
        tick(1);
        chk("t1_reset_mid_travel", r);
        rst = 1'b0;
        tick(5);
        chk("t1_after_reset", r);
        foreach (tbl[i]) begin
            do_reset();
            sb.push_back(tbl[i].exp);
            pulse(tbl[i].car, tbl[i].up, tbl[i].dn);
            tick(tbl[i].k - 1);
            e = sb.pop_front();
            chk($sformatf("vec%0d", i), e);
        end
        do_reset();
        pulse(4'h1, 4'h0, 4'h0);
        wait_door(n);
        chk_int("t2_latency", n + 1, 2);
        door_len(n, hits);
        chk_int("t2_dwell", n, 8);
        chk_int("t2_pend_in_door", hits, 0);
        chk("t2_idle", r);
        do_reset();
        pulse(4'h8, 4'h0, 4'h0);
        tick(1);
        chk("t4_start", mk(0, 1, 0, 0, 1, 1, 4'h8, 4'h0, 4'h0));
        pulse(4'h0, 4'h0, 4'h2);
        wait_floor(1, n);
        chk("t4_pass1", mk(1, 1, 0, 0, 1, 1, 4'h8, 4'h0, 4'h2));
        wait_door(n);
        chk("t4_serve3", mk(3, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h2));
        door_len(n, hits);
        chk("t4_reverse", mk(3, 0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h2));
        wait_door(n);
        chk("t4_serve1", mk(1, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0));
        door_len(n, hits);
        chk("t4_idle", mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));
        do_reset();
        pulse(4'h4, 4'h0, 4'h0);
        wait_door(n);
        chk("t5_at2", mk(2, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        door_hold = 1'b1;
        tick(20);
        door_hold = 1'b0;
        door_len(n, hits);
        chk_int("t5_hold_tail", n, 8);
        pulse(4'h4, 4'h0, 4'h0);
        wait_door(n);
        tick(2);
        pulse(4'h4, 4'h0, 4'h0);
        chk("t5_reopen_pend", mk(2, 0, 0, 1, 1, 1, 4'h0, 4'h0, 4'h0));
        door_len(n, hits);
        chk_int("t5_reopen_tail", n, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
Parametrised collective-control elevator car controller: N floors, SCAN (collective) dispatch, and separate pending registers for car, hall-up and hall-down calls.
- Travel takes a configurable number of cycles per floor.
- Door dwell is configurable and can be extended by a door-hold input.
- Hall calls are cleared only when served in their own direction.
- Sits between the button/lantern I/O block and the motor/door drive.

Parameters:
N_FLOORS, 8, number of floors (>=2)
FLOOR_BITS, $clog2(N_FLOORS), floor index width
TRAVEL_CYCLES, 16, cycles to travel one floor (>=1)
DOOR_CYCLES, 32, door dwell cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
car_call  in  N_FLOORS  car-panel button pulses/levels, one bit per floor
hall_up  in  N_FLOORS  hall up-call; bit N_FLOORS-1 ignored
hall_down  in  N_FLOORS  hall down-call; bit 0 ignored
door_hold  in  1  door-open button; restarts dwell while high
current_floor  out  FLOOR_BITS  floor the car is at or last passed
motor_up  out  1  drive up
motor_down  out  1  drive down
door_open  out  1  door open command
direction  out  1  1=up, 0=down
car_pend  out  N_FLOORS  latched car calls (panel lamps)
up_pend  out  N_FLOORS  latched hall-up calls
down_pend  out  N_FLOORS  latched hall-down calls
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - current_floor=0, direction=1.
  - motor_up, motor_down, door_open, busy = 0.
  - All pend vectors = 0; travel_cnt = 0; door_cnt = 0; state=IDLE.
  - Reset mid-motion or mid-dwell aborts immediately to these values.
- Pending latch:
  - pend <= (pend | in) & ~clr, per bit, one cycle after the input.
  - Ignored bits (hall_up[N-1], hall_down[0]) never set.
  - A set on the same cycle as a clear of that bit: clear wins.
- "ahead(d)" = any pending bit strictly beyond current_floor in direction d. "behind" is the mirror.
- FSM states: IDLE, MOVE, DOOR.
- IDLE:
  - Call pending at current_floor: enter DOOR.
    - direction becomes up if up_pend[f], else down if down_pend[f], else unchanged.
    - Clear car_pend[f] and the matching hall bit.
  - Else if ahead(direction): MOVE in direction.
  - Else if behind: flip direction and MOVE.
  - Last direction is preferred when calls exist on both sides.
- MOVE:
  - motor_up = direction, motor_down = ~direction.
  - travel_cnt counts 0..TRAVEL_CYCLES-1.
  - At terminal count: current_floor ± 1 and travel_cnt = 0, then evaluate stop at the new floor f.
  - Stop condition: car_pend[f], OR hall call in direction at f, OR (no ahead(direction) AND opposite hall call at f).
  - On stop: next state DOOR, motors deassert the same cycle floor updates, clear the served bits.
    - Opposite hall bit is cleared only if nothing is ahead; direction flips in that case.
  - No stop condition and nothing ahead: IDLE (defensive).
  - Floor never leaves 0..N_FLOORS-1.
- DOOR:
  - door_open=1; door_cnt counts 0..DOOR_CYCLES-1.
  - door_hold=1 holds door_cnt at 0.
  - A new call at current_floor matching direction (or a car call) is cleared immediately and door_cnt resets to 0 (reopen).
  - At terminal count:
    - If ahead(direction): MOVE.
    - Else if opposite hall call at f: flip direction, clear it, restart dwell.
    - Else if behind: flip direction, MOVE.
    - Else: IDLE.
- Latency:
  - Call at current floor in IDLE: door_open 2 cycles after the input.
  - Floor-to-floor travel: TRAVEL_CYCLES cycles.
- Width rules:
  - Counters are $clog2(max+1) bits.
  - Floor arithmetic is done at FLOOR_BITS+1 bits, so no wrap.

Decomposition:
- Package elevator_pkg holds:
  - state_t enum {IDLE, MOVE, DOOR}.
  - DIR_UP/DIR_DOWN constants.
  - Functions any_above(floor, vec) and any_below(floor, vec).
- One sub-module: elevator_call_latch.
  - Holds the three pend vectors with set/clear ports and masking of invalid hall bits.
  - Instantiated once.

Test Plan:
(N_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=8 throughout)
1. Reset, then idle 10 cycles -> current_floor=0, direction=1, all motors/door/pend=0, busy=0; assert rst mid-travel -> same values next cycle.
2. At floor 0, pulse car_call[0] -> door_open high 2 cycles later for exactly 8 cycles; car_pend[0] never seen high after entering DOOR; then IDLE.
3. At floor 0, pulse car_call[3] -> motor_up high; current_floor 1, 2, 3 at cycles 4, 8, 12 of travel; motor_up low and door_open high when floor=3; car_pend[3] cleared.
4. Moving up from 0 toward car_call[3]; pulse hall_down[1] -> car passes floor 1 without stopping and serves floor 3; after dwell it reverses, stops at 1 with direction=0, and down_pend[1] clears only then.
5. In DOOR at floor 2, hold door_hold for 20 cycles -> door_open stays high for 20+8 cycles total; a car_call[2] pulse mid-dwell restarts the 8-cycle count.
6. Pulse hall_up[3] and hall_down[0] -> up_pend/down_pend stay 0, state stays IDLE, busy=0.
